morph_window_unit: RTL and testbench



---
 rtl/morph_window_unit.sv | 168 ++++++++++++++++
 tb/tb_morph_window_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_window_unit.sv
// morph_window_unit
//   Binary-morphology kernel. Accepts one K x K pixel window per valid/ready
//   handshake, scans it serially (one element per clock) and returns a
//   full-scale or zero pixel. Erosion stops on the first background element.
//   Dilation stops on the first foreground element. The result is held until
//   downstream accepts it.
//
//   Optional feature macro: MORPH_THRESH_EN. When defined, a thr_i port
//   exists and an element counts as foreground when element >= thr. When
//   undefined, an element counts as foreground when it is non-zero.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset
//   en_i     block enable; low synchronously aborts and clears the block
//   mode_i   0 = erosion, 1 = dilation (sampled on accept)
//   win_i    K*K*W window, row-major; element e at [e*W +: W]
//   thr_i    foreground threshold (MORPH_THRESH_EN only)
//   valid_i  window valid
//   ready_o  block can accept a window
//   pix_o    result pixel (all ones or zero)
//   valid_o  result valid
//   ready_i  downstream accepts result
module morph_window_unit #(
  parameter int unsigned K = 3,
  parameter int unsigned W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [K*K*W-1:0] win_i,
`ifdef MORPH_THRESH_EN
  input  logic [W-1:0]     thr_i,
`endif
  input  logic             valid_i,
  output logic             ready_o,
  output logic [W-1:0]     pix_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int unsigned   N    = K * K;
  localparam int unsigned   IW   = $clog2(N) + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N*W-1:0]   win_q, win_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     pix_q, pix_d;
  logic             valid_q, valid_d;
`ifdef MORPH_THRESH_EN
  logic [W-1:0]     thr_q, thr_d;
`endif

  logic [W-1:0]     elem;
  logic             fg;
  logic             decisive;

  // Element under examination.
  always_comb begin
    elem = '0;
    for (int unsigned e = 0; e < N; e++) begin
      if (idx_q == e[IW-1:0]) elem = win_q[e*W +: W];
    end
  end

`ifdef MORPH_THRESH_EN
  assign fg = (elem >= thr_q);
`else
  assign fg = (elem != '0);
`endif

  // Erosion is decided by a background element, dilation by a foreground one.
  assign decisive = mode_q ? fg : !fg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    win_d   = win_q;
    mode_d  = mode_q;
    pix_d   = pix_q;
    valid_d = valid_q;
`ifdef MORPH_THRESH_EN
    thr_d   = thr_q;
`endif
    if (!en_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      win_d   = '0;
      mode_d  = 1'b0;
      pix_d   = '0;
      valid_d = 1'b0;
`ifdef MORPH_THRESH_EN
      thr_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            win_d   = win_i;
            mode_d  = mode_i;
`ifdef MORPH_THRESH_EN
            thr_d   = thr_i;
`endif
            idx_d   = '0;
            state_d = S_SCAN;
          end
        end
        S_SCAN: begin
          if (decisive) begin
            // Decisive element: dilation gives ones, erosion gives zero.
            pix_d   = {W{mode_q}};
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (idx_q == LAST) begin
            // Scan exhausted: erosion saw all foreground, dilation saw none.
            pix_d   = {W{~mode_q}};
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      win_q   <= '0;
      mode_q  <= 1'b0;
      pix_q   <= '0;
      valid_q <= 1'b0;
`ifdef MORPH_THRESH_EN
      thr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      win_q   <= win_d;
      mode_q  <= mode_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
`ifdef MORPH_THRESH_EN
      thr_q   <= thr_d;
`endif
    end
  end

  // rst_i gates ready_o so it stays low for the whole time reset is held.
  assign ready_o = (state_q == S_IDLE) && en_i && !rst_i;
  assign pix_o   = pix_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_morph_window_unit.sv
module tb_morph_window_unit;

  localparam int unsigned K  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = K * K;
  localparam int unsigned NW = N * W;

  logic          clk;
  logic          rst_i;
  logic          en_i;
  logic          mode_i;
  logic [NW-1:0] win_i;
`ifdef MORPH_THRESH_EN
  logic [W-1:0]  thr_i;
`endif
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  pix_o;
  logic          valid_o;
  logic          ready_i;

  int total = 0;
  int bad   = 0;

  morph_window_unit #(.K(K), .W(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .win_i   (win_i),
`ifdef MORPH_THRESH_EN
    .thr_i   (thr_i),
`endif
    .valid_i (valid_i),
    .ready_o (ready_o),
    .pix_o   (pix_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference: erosion = all elements foreground, dilation = any element
  // foreground; the decisive index is the first element that settles it.
  function automatic void model(input logic [NW-1:0] win, input logic mode,
                                input logic [W-1:0] thr,
                                output logic [W-1:0] pix, output int j);
    int nfg      = 0;
    int first_fg = -1;
    int first_bg = -1;
    logic [W-1:0] px;
    for (int e = 0; e < N; e++) begin
      px = win[e*W +: W];
      if (px >= thr) begin
        nfg++;
        if (first_fg < 0) first_fg = e;
      end else if (first_bg < 0) begin
        first_bg = e;
      end
    end
    if (!mode) begin
      pix = (nfg == N) ? '1 : '0;
      j   = (first_bg < 0) ? N - 1 : first_bg;
    end else begin
      pix = (nfg > 0) ? '1 : '0;
      j   = (first_fg < 0) ? N - 1 : first_fg;
    end
  endfunction

  function automatic logic [NW-1:0] rand_win();
    logic [NW-1:0] w;
    int unsigned pz;
    pz = $urandom_range(0, 100);
    for (int e = 0; e < N; e++) begin
      if ($urandom_range(0, 99) < pz) w[e*W +: W] = '0;
      else w[e*W +: W] = W'($urandom_range(1, (1 << W) - 1));
    end
    return w;
  endfunction

  task automatic set_thr(input logic [W-1:0] thr);
`ifdef MORPH_THRESH_EN
    thr_i = thr;
`else
    if (thr != 8'h01) $display("note: threshold %0h ignored in this build", thr);
`endif
  endtask

  // Called and returns at a negative edge. hold = cycles ready_i stays low
  // after valid_o rises (0 = ready_i high throughout).
  task automatic run_txn(input logic [NW-1:0] win, input logic mode,
                         input logic [W-1:0] thr, input int hold, input string name);
    logic [W-1:0] exp_pix;
    int exp_j;
    int lat;
    bit seen;
    model(win, mode, thr, exp_pix, exp_j);
    win_i   = win;
    mode_i  = mode;
    set_thr(thr);
    valid_i = 1'b1;
    ready_i = (hold == 0);
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, ready_o);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    win_i   = rand_win();
    mode_i  = ~mode;
    set_thr(8'h01);
    seen = 0;
    lat  = 0;
    for (int c = 1; c <= int'(N) + 4 && !seen; c++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        seen = 1;
        lat  = c;
      end
    end
    total++;
    if (!seen || lat != exp_j + 2) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d (seen=%0d)", name, lat, exp_j + 2, seen);
    end
    if (!seen) begin
      en_i = 1'b0;
      @(negedge clk);
      en_i = 1'b1;
      return;
    end
    total++;
    if (pix_o !== exp_pix) begin
      bad++;
      $display("FAIL %s pix: got %h want %h", name, pix_o, exp_pix);
    end
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        win_i   = rand_win();
        mode_i  = 1'($urandom);
        valid_i = 1'b1;
        @(negedge clk);
        total++;
        if (valid_o !== 1'b1 || pix_o !== exp_pix || ready_o !== 1'b0) begin
          bad++;
          $display("FAIL %s hold%0d: got valid=%b pix=%h ready=%b want 1 %h 0",
                   name, h, valid_o, pix_o, ready_o, exp_pix);
        end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
    end
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || pix_o !== exp_pix) begin
      bad++;
      $display("FAIL %s release: got valid=%b ready=%b pix=%h want 0 1 %h",
               name, valid_o, ready_o, pix_o, exp_pix);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (pix_o !== '0 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got pix=%h valid=%b ready=%b want 00 0 0", pix_o, valid_o, ready_o);
    end
    #2 rst_i = 1'b0;
    @(negedge clk);
    total++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_directed();
    logic [NW-1:0] w;
    w = '1;
    run_txn(w, 1'b0, 8'h01, 0, "ero_all_ff");
    w = '1; w[0 +: W] = '0;
    run_txn(w, 1'b0, 8'h01, 0, "ero_e0_zero");
    w = '1; w[8*W +: W] = '0;
    run_txn(w, 1'b0, 8'h01, 0, "ero_e8_zero");
    w = '0;
    run_txn(w, 1'b1, 8'h01, 0, "dil_all_zero");
    w = '0; w[4*W +: W] = 8'h01;
    run_txn(w, 1'b1, 8'h01, 0, "dil_e4_one");
  endtask

  task automatic test_backpressure();
    logic [NW-1:0] w;
    w = '0; w[2*W +: W] = 8'h33;
    run_txn(w, 1'b1, 8'h01, 5, "backpressure");
    for (int c = 0; c < int'(N) + 2; c++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        bad++;
        $display("FAIL ignored_valid c%0d: got valid=%b ready=%b want 0 1", c, valid_o, ready_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) run_txn(rand_win(), 1'(t), 8'h01, 0, "b2b");
  endtask

  task automatic test_enable_abort();
    logic [NW-1:0] w;
    w = '0; w[0 +: W] = 8'h80;
    run_txn(w, 1'b1, 8'h01, 0, "pre_abort");
    win_i   = '1;
    mode_i  = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_midscan: got valid=%b want 0", valid_o);
    end
    en_i = 1'b0;
    @(negedge clk);
    total++;
    if (valid_o !== 1'b0 || pix_o !== '0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: got valid=%b pix=%h ready=%b want 0 00 0", valid_o, pix_o, ready_o);
    end
    en_i = 1'b1;
    for (int c = 0; c < int'(N) + 3; c++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0 || pix_o !== '0 || ready_o !== 1'b1) begin
        bad++;
        $display("FAIL abort_stale c%0d: got valid=%b pix=%h ready=%b want 0 00 1",
                 c, valid_o, pix_o, ready_o);
      end
    end
  endtask

  task automatic test_async_reset();
    int c;
    win_i   = '0;
    win_i[0 +: W] = 8'h05;
    mode_i  = 1'b1;
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk);
    #1 valid_i = 1'b0;
    c = 0;
    while (valid_o !== 1'b1 && c < int'(N) + 4) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (valid_o !== 1'b1 || pix_o !== 8'hFF) begin
      bad++;
      $display("FAIL rst_pre_done: got valid=%b pix=%h want 1 ff", valid_o, pix_o);
    end
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (valid_o !== 1'b0 || pix_o !== '0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got valid=%b pix=%h ready=%b want 0 00 0", valid_o, pix_o, ready_o);
    end
    #1 rst_i = 1'b0;
    @(negedge clk);
    ready_i = 1'b1;
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready_after: got %b want 1", ready_o);
    end
    for (int k = 0; k < int'(N) + 3; k++) begin
      @(negedge clk);
      total++;
      if (valid_o !== 1'b0 || pix_o !== '0) begin
        bad++;
        $display("FAIL rst_stale k%0d: got valid=%b pix=%h want 0 00", k, valid_o, pix_o);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] thr;
    for (int t = 0; t < 40; t++) begin
`ifdef MORPH_THRESH_EN
      thr = W'($urandom_range(0, (1 << W) - 1));
`else
      thr = 8'h01;
`endif
      run_txn(rand_win(), 1'($urandom), thr, int'($urandom_range(0, 3)), "random");
    end
  endtask

`ifdef MORPH_THRESH_EN
  task automatic test_thresh();
    logic [NW-1:0] w;
    w = {N{8'h80}};
    w[5*W +: W] = 8'h7F;
    run_txn(w, 1'b0, 8'h80, 0, "thr_ero_7f");
    w = {N{8'h80}};
    run_txn(w, 1'b0, 8'h80, 0, "thr_ero_all80");
    w = '0;
    run_txn(w, 1'b0, 8'h00, 0, "thr_zero_allfg");
  endtask
`endif

  initial begin
    rst_i   = 1'b1;
    en_i    = 1'b1;
    mode_i  = 1'b0;
    win_i   = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
`ifdef MORPH_THRESH_EN
    thr_i   = 8'h01;
`endif
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_enable_abort();
    test_async_reset();
    test_random();
`ifdef MORPH_THRESH_EN
    test_thresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
